// File: rtl/multi_byte_adder_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-byte adder sequencer.
// Keeps the FSM encoding and slice width in one place for the top, interface and bench.
package multi_byte_adder_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, ADD, DONE} seq_state_t;

  localparam int BYTE_WIDTH = 8;

  // A single-slice sequencer still needs a 1-bit index register.
  function automatic int idx_width(input int num_bytes);
    return (num_bytes <= 1) ? 1 : $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/multi_byte_adder_sequencer_if.sv
// Requester/consumer bundle of the sequencer: start/ready on the request side, valid/ready on the result side.
// The master modport is the requester+consumer; the slave modport is the sequencer itself.
interface multi_byte_adder_sequencer_if #(parameter int NUM_BYTES = 4);
  import multi_byte_adder_sequencer_pkg::*;

  localparam int W = BYTE_WIDTH * NUM_BYTES;

  logic         Start_In;
  logic         Ready_Out;
  logic [W-1:0] Data_A_In;
  logic [W-1:0] Data_B_In;
  logic         Carry_In;
  logic [W-1:0] Sum_Out;
  logic         Carry_Out;
  logic         Valid_Out;
  logic         Result_Ready_In;

  modport master (
    output Start_In, Data_A_In, Data_B_In, Carry_In, Result_Ready_In,
    input  Ready_Out, Sum_Out, Carry_Out, Valid_Out
  );

  modport slave (
    input  Start_In, Data_A_In, Data_B_In, Carry_In, Result_Ready_In,
    output Ready_Out, Sum_Out, Carry_Out, Valid_Out
  );

endinterface

// File: rtl/multi_byte_adder_sequencer_adder.sv
// 8-bit carry-lookahead adder; purely combinational, zero latency, no flow control.
// Outputs float (high-Z) whenever Enable_In is low.
module Adder_with_Look_Ahead_Carry_Generator_8_Bit (
  input  logic [7:0] A_In,
  input  logic [7:0] B_In,
  input  logic       Carry_In,
  input  logic       Enable_In,
  output wire  [7:0] Sum_Out,
  output wire        Carry_Out
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [7:0] carry;
  logic       carry_top;
  logic       run;

  always_comb begin
    gen       = A_In & B_In;
    prop      = A_In ^ B_In;
    carry     = '0;
    run       = Carry_In;
    for (int i = 0; i < 8; i++) begin
      carry[i] = run;
      run      = gen[i] | (prop[i] & run);
    end
    carry_top = run;
  end

  assign Sum_Out   = Enable_In ? (prop ^ carry) : 8'bz;
  assign Carry_Out = Enable_In ? carry_top : 1'bz;

endmodule

// File: rtl/multi_byte_adder_sequencer.sv
// Runs a NUM_BYTES*8-bit add through one 8-bit adder, one slice per cycle LSB first; result valid NUM_BYTES cycles after acceptance.
// Request side stalls (Ready_Out low) outside IDLE; result is held in DONE until Result_Ready_In.
module multi_byte_adder_sequencer
  import multi_byte_adder_sequencer_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic Clock_In,
  input  logic Reset_In,
  multi_byte_adder_sequencer_if.slave bus
);

  localparam int W  = BYTE_WIDTH * NUM_BYTES;
  localparam int IW = idx_width(NUM_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [IW-1:0] byte_idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;

  logic          add_en;
  logic          last_slice;
  wire  [7:0]    add_sum;
  wire           add_cout;

  assign add_en     = (state == ADD);
  assign last_slice = (byte_idx == LAST_IDX);

  Adder_with_Look_Ahead_Carry_Generator_8_Bit u_adder (
    .A_In      (a_q[BYTE_WIDTH*byte_idx +: BYTE_WIDTH]),
    .B_In      (b_q[BYTE_WIDTH*byte_idx +: BYTE_WIDTH]),
    .Carry_In  (carry_q),
    .Enable_In (add_en),
    .Sum_Out   (add_sum),
    .Carry_Out (add_cout)
  );

  always_ff @(posedge Clock_In) begin
    if (Reset_In) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start_In)        state_nxt = ADD;
      ADD:     if (last_slice)          state_nxt = DONE;
      DONE:    if (bus.Result_Ready_In) state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Adder outputs are only captured in ADD; in DONE they are high-Z.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start_In) begin
            a_q      <= bus.Data_A_In;
            b_q      <= bus.Data_B_In;
            carry_q  <= bus.Carry_In;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            byte_idx <= '0;
          end
        end
        ADD: begin
          sum_q[BYTE_WIDTH*byte_idx +: BYTE_WIDTH] <= add_sum;
          carry_q <= add_cout;
          if (last_slice) cout_q   <= add_cout;
          else            byte_idx <= byte_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Ready_Out = (state == IDLE);
  assign bus.Valid_Out = (state == DONE);
  assign bus.Sum_Out   = sum_q;
  assign bus.Carry_Out = cout_q;

endmodule

// File: tb/tb_multi_byte_adder_sequencer.sv
// Bench for the multi-byte adder sequencer: scoreboarded 4-byte instance plus a directed 1-byte instance.
module tb_multi_byte_adder_sequencer;

  bit   clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [32:0] exp_q[$];
  int          acc_q[$];
  logic        prev_vld = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multi_byte_adder_sequencer_if #(.NUM_BYTES(4)) b4 ();
  multi_byte_adder_sequencer_if #(.NUM_BYTES(1)) b1 ();

  multi_byte_adder_sequencer #(.NUM_BYTES(4)) dut4 (.Clock_In(clk), .Reset_In(rst), .bus(b4));
  multi_byte_adder_sequencer #(.NUM_BYTES(1)) dut1 (.Clock_In(clk), .Reset_In(rst), .bus(b1));

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 33'(c);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: latency check on every rising Valid_Out, value check on every handshake.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (b4.Valid_Out && !prev_vld) begin
        if (acc_q.size() != 0) chk("latency", 64'(cyc - acc_q.pop_front()), 64'd4);
        else begin
          total++; bad++;
          $display("FAIL latency: Valid_Out rose with no accepted request (cycle %0d)", cyc);
        end
      end
      if (b4.Valid_Out && b4.Result_Ready_In) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL result: unexpected result sum=0x%0h, required none", b4.Sum_Out);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("sum", 64'(b4.Sum_Out), 64'(e[31:0]));
          chk("carry", 64'(b4.Carry_Out), 64'(e[32]));
        end
      end
    end
    prev_vld = b4.Valid_Out;
  end

  task automatic wait_ready();
    int n = 0;
    while (!b4.Ready_Out && n < 50) begin step(); n++; end
    if (!b4.Ready_Out) begin
      total++; bad++;
      $display("FAIL ready_timeout: Ready_Out=0 after 50 cycles, required 1");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c);
    wait_ready();
    b4.Data_A_In = a;
    b4.Data_B_In = b;
    b4.Carry_In  = c;
    b4.Start_In  = 1'b1;
    exp_q.push_back(ref_add(a, b, c));
    acc_q.push_back(cyc + 1);
    step();
    b4.Start_In  = 1'b0;
    b4.Data_A_In = $urandom;
    b4.Data_B_In = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin step(); n++; end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] e;
    int          last_acc;
    int          n;

    rst = 1'b1;
    b4.Start_In = 1'b0; b4.Data_A_In = '0; b4.Data_B_In = '0; b4.Carry_In = 1'b0; b4.Result_Ready_In = 1'b1;
    b1.Start_In = 1'b0; b1.Data_A_In = '0; b1.Data_B_In = '0; b1.Carry_In = 1'b0; b1.Result_Ready_In = 1'b0;
    repeat (3) step();
    chk("rst_ready", 64'(b4.Ready_Out), 64'd1);
    chk("rst_valid", 64'(b4.Valid_Out), 64'd0);
    chk("rst_sum",   64'(b4.Sum_Out),   64'd0);
    chk("rst_carry", 64'(b4.Carry_Out), 64'd0);
    rst = 1'b0;
    step();

    // Full carry ripple across all slices.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_drain();

    // Start pulse while busy must be ignored.
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    chk("ready_in_add", 64'(b4.Ready_Out), 64'd0);
    b4.Data_A_In = 32'h1111_1111;
    b4.Data_B_In = 32'h2222_2222;
    b4.Start_In  = 1'b1;
    step();
    b4.Start_In  = 1'b0;
    wait_drain();

    // Backpressure: result held for 6 cycles.
    b4.Result_Ready_In = 1'b0;
    ra = $urandom; rb = $urandom; rc = 1'($urandom);
    e  = ref_add(ra, rb, rc);
    issue(ra, rb, rc);
    n = 0;
    while (!b4.Valid_Out && n < 20) begin step(); n++; end
    chk("bp_valid_seen", 64'(b4.Valid_Out), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_valid_hold", 64'(b4.Valid_Out), 64'd1);
      chk("bp_sum_hold",   64'(b4.Sum_Out),   64'(e[31:0]));
      chk("bp_carry_hold", 64'(b4.Carry_Out), 64'(e[32]));
    end
    b4.Result_Ready_In = 1'b1;
    step();
    chk("bp_ready_after", 64'(b4.Ready_Out), 64'd1);
    chk("bp_sum_idle",    64'(b4.Sum_Out),   64'(e[31:0]));
    wait_drain();

    // Reset in the middle of ADD aborts the operation.
    issue($urandom, $urandom, 1'b1);
    step();
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    step();
    rst = 1'b0;
    chk("abort_ready", 64'(b4.Ready_Out), 64'd1);
    chk("abort_valid", 64'(b4.Valid_Out), 64'd0);
    chk("abort_sum",   64'(b4.Sum_Out),   64'd0);
    chk("abort_carry", 64'(b4.Carry_Out), 64'd0);
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_drain();

    // Back-to-back random operands with Start_In and Result_Ready_In held high.
    b4.Result_Ready_In = 1'b1;
    b4.Start_In = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 10; i++) begin
      wait_ready();
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      b4.Data_A_In = ra;
      b4.Data_B_In = rb;
      b4.Carry_In  = rc;
      exp_q.push_back(ref_add(ra, rb, rc));
      acc_q.push_back(cyc + 1);
      if (i > 0) chk("issue_period", 64'(cyc + 1 - last_acc), 64'd6);
      last_acc = cyc + 1;
      step();
    end
    b4.Start_In = 1'b0;
    wait_drain();

    // Single-slice instance: 0x80 + 0x80 + 1.
    b1.Data_A_In = 8'h80;
    b1.Data_B_In = 8'h80;
    b1.Carry_In  = 1'b1;
    b1.Start_In  = 1'b1;
    chk("nb1_ready", 64'(b1.Ready_Out), 64'd1);
    step();
    b1.Start_In = 1'b0;
    chk("nb1_valid_early", 64'(b1.Valid_Out), 64'd0);
    step();
    chk("nb1_valid", 64'(b1.Valid_Out), 64'd1);
    chk("nb1_sum",   64'(b1.Sum_Out),   64'h01);
    chk("nb1_carry", 64'(b1.Carry_Out), 64'd1);
    b1.Result_Ready_In = 1'b1;
    step();
    chk("nb1_ready_after", 64'(b1.Ready_Out), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
